// File: rtl/canvas_pkg.sv
// Shared definitions for the canvas write-port arbiter.
package canvas_pkg;

  localparam int unsigned AddrWDefault = 10;
  localparam int unsigned CanvasDepth  = 1 << AddrWDefault;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } arb_state_e;

endpackage

// File: rtl/canvas_write_arbiter_if.sv
// Pen request, clear control and canvas memory write-port signal bundle.
interface canvas_write_arbiter_if #(
  parameter int unsigned ADDR_W = canvas_pkg::AddrWDefault
);

  logic              pen_req;
  logic [ADDR_W-1:0] pen_addr;
  logic              pen_data;
  logic              pen_ack;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_din;

  // Requester / memory side.
  modport master (
    output pen_req, pen_addr, pen_data, clear_start,
    input  pen_ack, clear_busy, clear_done, mem_we, mem_addr, mem_din
  );

  // Arbiter side.
  modport slave (
    input  pen_req, pen_addr, pen_data, clear_start,
    output pen_ack, clear_busy, clear_done, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/clear_addr_gen.sv
// Clear-sweep address counter: load to zero, increment, saturate at the last address.
module clear_addr_gen
  import canvas_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = '0;
    end else if (inc_i && !last_o) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = &addr_q;

endmodule

// File: rtl/canvas_write_arbiter.sv
// Arbitrates the single canvas write port between a pen requester and a full-canvas clear
// sweep; all outputs are registered.
module canvas_write_arbiter
  import canvas_pkg::*;
#(
  parameter int unsigned ADDR_W    = AddrWDefault,
  parameter logic        CLEAR_VAL = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  canvas_write_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;

  logic              pen_ack_q, pen_ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              din_q, din_d;

  // Last committed pen write, used to drop redundant rewrites.
  logic              rec_valid_q, rec_valid_d;
  logic [ADDR_W-1:0] rec_addr_q, rec_addr_d;
  logic              rec_data_q, rec_data_d;

  logic              cnt_load, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic              rec_hit;

  clear_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_clear_addr_gen (
    .clk_i (clk),
    .rst_ni(rst),
    .load_i(cnt_load),
    .inc_i (cnt_inc),
    .addr_o(cnt_addr),
    .last_o(cnt_last)
  );

  assign rec_hit = rec_valid_q && (rec_addr_q == bus.pen_addr) && (rec_data_q == bus.pen_data);

  always_comb begin
    state_d     = state_q;
    pen_ack_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    rec_valid_d = rec_valid_q;
    rec_addr_d  = rec_addr_q;
    rec_data_d  = rec_data_q;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.clear_start) begin
          // Clear wins; address 0 is presented right away so the sweep has no lead bubble.
          state_d  = StClear;
          cnt_load = 1'b1;
          we_d     = 1'b1;
          addr_d   = '0;
          din_d    = CLEAR_VAL;
          busy_d   = 1'b1;
        end else if (bus.pen_req) begin
          pen_ack_d = 1'b1;
          if (!rec_hit) begin
            we_d        = 1'b1;
            addr_d      = bus.pen_addr;
            din_d       = bus.pen_data;
            rec_valid_d = 1'b1;
            rec_addr_d  = bus.pen_addr;
            rec_data_d  = bus.pen_data;
          end
        end
      end
      StClear: begin
        // cnt_addr tracks the address currently on the port.
        if (cnt_last) begin
          state_d     = StDone;
          done_d      = 1'b1;
          rec_valid_d = 1'b0;
        end else begin
          cnt_inc = 1'b1;
          we_d    = 1'b1;
          addr_d  = cnt_addr + ADDR_W'(1);
          din_d   = CLEAR_VAL;
          busy_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pen_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_addr_q  <= '0;
      rec_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pen_ack_q   <= pen_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rec_valid_q <= rec_valid_d;
      rec_addr_q  <= rec_addr_d;
      rec_data_q  <= rec_data_d;
    end
  end

  assign bus.pen_ack    = pen_ack_q;
  assign bus.clear_busy = busy_q;
  assign bus.clear_done = done_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;

endmodule
